alb_result_stage: RTL and testbench

- Parametrised, registered successor to the ALB function-output mux.
- Takes one of NUM_SRC functional-unit results per operation and derives the C/V/N/Z flags.
- Buffers operations in a 2-entry skid FIFO with valid/ready handshakes on both sides.
- Maintains an architectural flag register and sticky overflow/error status. Sits between the ALB functional units and the register-file write-back.

---
 rtl/alb_pkg.sv | 23 ++
 rtl/alb_flag_gen.sv | 44 ++++
 rtl/alb_result_stage.sv | 126 ++++++++++++
 tb/tb_alb_result_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alb_pkg.sv
// Shared definitions for the ALB result path: flag bit positions, the reset
// flag value and the buffered-entry record.
package alb_pkg;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    localparam logic [3:0] FLAGS_RST = 4'b0100;

    localparam int ALB_DATA_W = 8;

    // Entry record at the default result width; wider instances of the stage
    // keep an identically laid-out record sized by their own DATA_WIDTH.
    typedef struct packed {
        logic [ALB_DATA_W-1:0] data;
        logic [3:0]            flags;
        logic                  flag_we;
        logic                  err;
    } alb_entry_t;

endpackage

// File: rtl/alb_flag_gen.sv
// Combinational source select and {N,Z,C,V} derivation for one operation.
// Out-of-range selects yield a zero result with only Z set and raise err_o.
module alb_flag_gen
    import alb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4,
    parameter int SEL_W      = 2
) (
    input  logic [SEL_W-1:0]            sel_i,
    input  logic                        arith_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i,
    input  logic [NUM_SRC-1:0]          src_c_i,
    input  logic [NUM_SRC-1:0]          src_v_i,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic [3:0]                  flags_o,
    output logic                        err_o
);

    logic c_sel;
    logic v_sel;

    always_comb begin
        data_o = '0;
        c_sel  = 1'b0;
        v_sel  = 1'b0;
        err_o  = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel_i == SEL_W'(k)) begin
                data_o = src_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                c_sel  = src_c_i[k] & arith_i;
                v_sel  = src_v_i[k] & arith_i;
                err_o  = 1'b0;
            end
        end

        flags_o        = '0;
        flags_o[FLG_N] = data_o[DATA_WIDTH-1];
        flags_o[FLG_Z] = (data_o == '0);
        flags_o[FLG_C] = c_sel;
        flags_o[FLG_V] = v_sel;
    end

endmodule

// File: rtl/alb_result_stage.sv
// Registered ALB result stage: source select + flag derivation feeding a
// 2-entry in-order skid buffer, architectural flag register and sticky status.
module alb_result_stage
    import alb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4,
    parameter int SEL_W      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SEL_W-1:0]              in_sel,
    input  logic                          in_arith,
    input  logic                          in_flag_we,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            src_c,
    input  logic [NUM_SRC-1:0]            src_v,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [3:0]                    out_flags,
    output logic [3:0]                    flags_q,
    output logic                          sticky_v,
    output logic                          sel_err,
    input  logic                          clr_sticky
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [3:0]            flags;
        logic                  flag_we;
        logic                  err;
    } entry_t;

    logic [DATA_WIDTH-1:0] gen_data;
    logic [3:0]            gen_flags;
    logic                  gen_err;

    alb_flag_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SRC    (NUM_SRC),
        .SEL_W      (SEL_W)
    ) u_flag_gen (
        .sel_i      (in_sel),
        .arith_i    (in_arith),
        .src_data_i (src_data),
        .src_c_i    (src_c),
        .src_v_i    (src_v),
        .data_o     (gen_data),
        .flags_o    (gen_flags),
        .err_o      (gen_err)
    );

    // Slot 0 is always the head; slot 1 is only meaningful when count_q == 2.
    entry_t [1:0] ent_q, ent_d;
    entry_t       new_ent;
    logic [1:0]   count_q, count_d;
    logic [3:0]   flags_d;
    logic         sticky_q, sticky_d;
    logic         sel_err_q, sel_err_d;
    logic         accept, retire;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;

    // Error entries always present a zero result regardless of stored data.
    assign out_data  = ent_q[0].err ? '0 : ent_q[0].data;
    assign out_flags = ent_q[0].flags;
    assign sticky_v  = sticky_q;
    assign sel_err   = sel_err_q;

    always_comb begin
        new_ent = '{data: gen_data, flags: gen_flags, flag_we: in_flag_we, err: gen_err};
        ent_d   = ent_q;
        count_d = count_q;
        case ({accept, retire})
            2'b10: begin
                if (count_q == 2'd0) ent_d[0] = new_ent;
                else                 ent_d[1] = new_ent;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                ent_d[0] = ent_q[1];
                count_d  = count_q - 2'd1;
            end
            2'b11: ent_d[0] = new_ent;
            default: ;
        endcase

        flags_d = (retire && ent_q[0].flag_we) ? ent_q[0].flags : flags_q;

        // Set events win over a same-cycle clear.
        if (retire && ent_q[0].flags[FLG_V]) sticky_d = 1'b1;
        else if (clr_sticky)                 sticky_d = 1'b0;
        else                                 sticky_d = sticky_q;

        if (accept && gen_err) sel_err_d = 1'b1;
        else if (clr_sticky)   sel_err_d = 1'b0;
        else                   sel_err_d = sel_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 2'd0;
            ent_q[0]  <= '{data: '0, flags: FLAGS_RST, flag_we: 1'b0, err: 1'b0};
            flags_q   <= FLAGS_RST;
            sticky_q  <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            ent_q[0]  <= ent_d[0];
            flags_q   <= flags_d;
            sticky_q  <= sticky_d;
            sel_err_q <= sel_err_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_q[1] <= ent_d[1];
    end

endmodule

// File: tb/tb_alb_result_stage.sv
// Self-checking bench for alb_result_stage (NUM_SRC = 3 so select 3 is out of range).
module tb_alb_result_stage;

    localparam int DW = 8;
    localparam int NS = 3;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [SW-1:0]   in_sel = '0;
    logic            in_arith = 1'b0;
    logic            in_flag_we = 1'b0;
    logic [NS*DW-1:0] src_data = '0;
    logic [NS-1:0]   src_c = '0;
    logic [NS-1:0]   src_v = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   out_data;
    logic [3:0]      out_flags;
    logic [3:0]      flags_q;
    logic            sticky_v;
    logic            sel_err;
    logic            clr_sticky = 1'b0;

    always #5 clk = ~clk;

    alb_result_stage #(.DATA_WIDTH(DW), .NUM_SRC(NS), .SEL_W(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_arith   (in_arith),
        .in_flag_we (in_flag_we),
        .src_data   (src_data),
        .src_c      (src_c),
        .src_v      (src_v),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_flags  (out_flags),
        .flags_q    (flags_q),
        .sticky_v   (sticky_v),
        .sel_err    (sel_err),
        .clr_sticky (clr_sticky)
    );

    typedef struct {
        logic [7:0] d;
        logic [3:0] f;
        bit         we;
        bit         err;
    } ment_t;

    typedef struct {
        int         sel;
        bit         arith;
        bit         we;
        logic [7:0] d;
        bit         c;
        bit         v;
        logic [7:0] exp_d;
        logic [3:0] exp_f;
    } vec_t;

    ment_t      mq[$];
    logic [3:0] m_flags = 4'b0100;
    bit         m_sticky = 1'b0;
    bit         m_selerr = 1'b0;
    logic [7:0] rlog[$];
    int         n_tests = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: flags straight from the arithmetic meaning of the result byte.
    function automatic ment_t ref_op(input int sel, input bit arith, input bit we,
                                     input logic [NS*DW-1:0] sd,
                                     input logic [NS-1:0] c, input logic [NS-1:0] v);
        ment_t e;
        int    d;
        e.we = we;
        if (sel >= NS) begin
            e.d = 8'h00; e.f = 4'b0100; e.err = 1'b1;
            return e;
        end
        d     = int'(sd >> (DW * sel)) % 256;
        e.d   = 8'(d);
        e.f   = {d >= 128, d == 0, c[sel] & arith, v[sel] & arith};
        e.err = 1'b0;
        return e;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
        chk({tag, "_in_ready"},  32'(in_ready),  32'(mq.size() < 2));
        chk({tag, "_flags_q"},   32'(flags_q),   32'(m_flags));
        chk({tag, "_sticky_v"},  32'(sticky_v),  32'(m_sticky));
        chk({tag, "_sel_err"},   32'(sel_err),   32'(m_selerr));
        if (mq.size() > 0) begin
            chk({tag, "_out_data"},  32'(out_data),  32'(mq[0].d));
            chk({tag, "_out_flags"}, 32'(out_flags), 32'(mq[0].f));
        end
    endtask

    task automatic tick(input string tag, output bit acc);
        ment_t nw, hd;
        bit    ret;
        nw  = ref_op(int'(in_sel), in_arith, in_flag_we, src_data, src_c, src_v);
        acc = in_valid && (mq.size() < 2) && !rst;
        ret = (mq.size() > 0) && out_ready && !rst;
        if (ret) rlog.push_back(out_data);
        if (rst) begin
            mq.delete();
            m_flags = 4'b0100; m_sticky = 1'b0; m_selerr = 1'b0;
        end else begin
            if (ret) begin
                hd = mq.pop_front();
                if (hd.we) m_flags = hd.f;
            end
            if (ret && hd.f[0])   m_sticky = 1'b1;
            else if (clr_sticky)  m_sticky = 1'b0;
            if (acc && nw.err)    m_selerr = 1'b1;
            else if (clr_sticky)  m_selerr = 1'b0;
            if (acc) mq.push_back(nw);
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic set_op(input int sel, input bit arith, input bit we,
                          input logic [7:0] d, input bit c, input bit v);
        src_data = (NS*DW)'({$urandom, $urandom});
        src_c    = NS'($urandom);
        src_v    = NS'($urandom);
        in_sel   = SW'(sel);
        in_arith = arith;
        in_flag_we = we;
        if (sel < NS) begin
            src_data[sel*DW +: DW] = d;
            src_c[sel] = c;
            src_v[sel] = v;
        end
    endtask

    task automatic drain();
        bit a;
        in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
        for (int i = 0; i < 4; i++) tick("drain", a);
    endtask

    vec_t vecs[6];
    bit   a;

    initial begin
        vecs[0] = '{sel: 1, arith: 1, we: 1, d: 8'h80, c: 1, v: 1, exp_d: 8'h80, exp_f: 4'b1011};
        vecs[1] = '{sel: 1, arith: 0, we: 1, d: 8'h80, c: 1, v: 1, exp_d: 8'h80, exp_f: 4'b1000};
        vecs[2] = '{sel: 0, arith: 1, we: 0, d: 8'h00, c: 0, v: 0, exp_d: 8'h00, exp_f: 4'b0100};
        vecs[3] = '{sel: 2, arith: 1, we: 1, d: 8'h7F, c: 1, v: 0, exp_d: 8'h7F, exp_f: 4'b0010};
        vecs[4] = '{sel: 3, arith: 1, we: 1, d: 8'h55, c: 1, v: 1, exp_d: 8'h00, exp_f: 4'b0100};
        vecs[5] = '{sel: 0, arith: 1, we: 1, d: 8'h01, c: 0, v: 1, exp_d: 8'h01, exp_f: 4'b0001};

        // Reset state
        rst = 1'b1;
        tick("rst0", a);
        tick("rst1", a);
        rst = 1'b0;
        chk("rst_out_data",  32'(out_data),  32'h00);
        chk("rst_out_flags", 32'(out_flags), 32'h4);
        chk("rst_flags_q",   32'(flags_q),   32'h4);

        // Table-driven single operations with an always-ready consumer
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_op(vecs[i].sel, vecs[i].arith, vecs[i].we, vecs[i].d, vecs[i].c, vecs[i].v);
            in_valid = 1'b1;
            tick($sformatf("vec%0d_acc", i), a);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'h1);
            chk($sformatf("vec%0d_data", i),  32'(out_data),  32'(vecs[i].exp_d));
            chk($sformatf("vec%0d_flags", i), 32'(out_flags), 32'(vecs[i].exp_f));
            tick($sformatf("vec%0d_ret", i), a);
        end
        chk("vec_sel_err_set", 32'(sel_err), 32'h1);

        // New out-of-range select in the same cycle as clr_sticky: set wins
        set_op(3, 0, 0, 8'h00, 0, 0);
        in_valid = 1'b1; clr_sticky = 1'b1;
        tick("selerr_clr_same", a);
        in_valid = 1'b0; clr_sticky = 1'b0;
        chk("selerr_set_wins", 32'(sel_err), 32'h1);
        tick("selerr_idle", a);
        clr_sticky = 1'b1;
        tick("selerr_clr", a);
        clr_sticky = 1'b0;
        chk("selerr_cleared", 32'(sel_err), 32'h0);
        chk("sticky_cleared", 32'(sticky_v), 32'h0);

        // Overflow retiring in the same cycle as clr_sticky: set wins
        out_ready = 1'b0;
        set_op(0, 1, 0, 8'h05, 0, 1);
        in_valid = 1'b1;
        tick("stk_acc", a);
        in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b1;
        tick("stk_ret_clr", a);
        clr_sticky = 1'b0;
        chk("sticky_set_wins", 32'(sticky_v), 32'h1);
        drain();

        // Backpressure: three ops offered back to back with consumer stalled
        rlog.delete();
        out_ready = 1'b0;
        set_op(0, 0, 1, 8'h11, 0, 0); in_valid = 1'b1; tick("bp_op1", a);
        set_op(1, 0, 1, 8'h22, 0, 0); tick("bp_op2", a);
        set_op(2, 0, 1, 8'h33, 0, 0); tick("bp_op3_blocked", a);
        chk("bp_full_in_ready", 32'(in_ready), 32'h0);
        chk("bp_hold_op1",      32'(out_data), 32'h11);
        tick("bp_op3_blocked2", a);
        chk("bp_hold_op1_again", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        a = 1'b0;
        for (int i = 0; i < 10 && !a; i++) tick("bp_release", a);
        chk("bp_op3_accepted", 32'(a), 32'h1);
        drain();
        chk("bp_retire_count", 32'(rlog.size()), 32'd3);
        if (rlog.size() == 3) begin
            chk("bp_order0", 32'(rlog[0]), 32'h11);
            chk("bp_order1", 32'(rlog[1]), 32'h22);
            chk("bp_order2", 32'(rlog[2]), 32'h33);
        end

        // Reset with two entries buffered discards them
        out_ready = 1'b0;
        set_op(0, 1, 1, 8'hC0, 1, 1); in_valid = 1'b1; tick("rb_op1", a);
        set_op(1, 1, 1, 8'h81, 1, 1); tick("rb_op2", a);
        chk("rb_full", 32'(in_ready), 32'h0);
        rst = 1'b1; out_ready = 1'b1;
        tick("rb_rst", a);
        rst = 1'b0; in_valid = 1'b0;
        chk("rb_out_valid", 32'(out_valid), 32'h0);
        chk("rb_in_ready",  32'(in_ready),  32'h1);
        chk("rb_flags_q",   32'(flags_q),   32'h4);
        chk("rb_sticky_v",  32'(sticky_v),  32'h0);
        chk("rb_sel_err",   32'(sel_err),   32'h0);
        chk("rb_out_data",  32'(out_data),  32'h00);
        chk("rb_out_flags", 32'(out_flags), 32'h4);
        tick("rb_after", a);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            set_op($urandom_range(0, 3), 1'($urandom), 1'($urandom), 8'($urandom),
                   1'($urandom), 1'($urandom));
            in_valid   = 1'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            clr_sticky = ($urandom_range(0, 15) == 0);
            tick("rand", a);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
